shift_exec_ctrl: RTL and testbench
==================================

# shift_exec_ctrl

Sequencing stage directly upstream of the ALU barrel shifter: accepts decoded RV32 shift operations over a valid/ready handshake, registers operands, drives the combinational shifter, captures its result and hands it to writeback over a second valid/ready handshake. One shifter instance is shared; optional Zbb rotates are built from two shifter passes under a small FSM.

## Interface
Parameters:
- none (datapath fixed at 32 bits, shift amount 5 bits)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream operation valid
- in_ready  out  1  stage can accept
- in_funct3  in  3  RV32 funct3
- in_funct7  in  7  RV32 funct7 (imm[11:5] for immediate forms)
- in_op_a  in  32  rs1 value
- in_op_b  in  32  rs2 value or shamt; only [4:0] used
- in_rd  in  5  destination register tag, passed through
- sh_opranda  out  32  to shifter data input
- sh_oprandb  out  5  to shifter amount
- sh_right_flag  out  1  to shifter: 1 = right shift
- sh_right_arith_flag  out  1  to shifter: 1 = sign fill
- sh_res  in  32  shifter result (combinational, same cycle)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_result  out  32  shift result
- out_rd  out  5  tag of result
- out_illegal  out  1  operation was not a supported shift

## Operation
- Decode (funct3/funct7): 001/0000000 SLL; 101/0000000 SRL; 101/0100000 SRA; with macro, 001/0110000 ROL and 101/0110000 ROR. Anything else illegal.
- States: IDLE, EXEC1, EXEC2, DONE.
- IDLE: in_ready=1. On accept, latch op_a, op_b[4:0], rd, decoded op -> EXEC1.
- EXEC1: drive shifter from latched regs. SLL: right=0. SRL: right=1, arith=0. SRA: right=1, arith=1. ROL: left by n. ROR: right logical by n. Non-rotate: capture sh_res into out_result -> DONE. Rotate: capture sh_res into partial register -> EXEC2.
- EXEC2 (rotate only): second pass, opposite direction, logical, amount (32-n) mod 32 (5-bit wrap); out_result = partial | sh_res -> DONE. n=0 yields op_a unchanged (both passes are identity).
- Illegal: no shifter use; out_result=0, out_illegal=1, same path as non-rotate (IDLE->EXEC1->DONE).
- DONE: out_valid=1; out_result/out_rd/out_illegal stable until handshake. On out_ready: in_ready=1 combinationally; if in_valid also high, accept new op and go to EXEC1 (no bubble); else IDLE.
- sh_* outputs hold last driven values outside EXEC states.
- Reset (any state, including mid-rotate): state IDLE; out_valid=0, out_result=0, out_rd=0, out_illegal=0, sh_*=0, partial=0; in_ready=0 while rst high, 1 the first cycle after.

## Timing
- Accept at edge of cycle N; EXEC1 in N+1; non-rotate/illegal out_valid from cycle N+2; rotate out_valid from N+3.
- Throughput: one shift per 2 cycles with out_ready held high; one rotate per 3 cycles.
- in_ready low in EXEC1/EXEC2 and in DONE while out_ready low.
- Shifter path is combinational within a single EXEC cycle; result registered at end of it.

## Configuration
- SHIFT_ZBB_ROT_EN defined: ROL/ROR decoded and executed via EXEC1+EXEC2.
- Not defined: funct7=0110000 decodes illegal; EXEC2 and partial register removed; FSM never leaves EXEC1 for anything but DONE.

## Test plan
- SRA op_a=0x80000000, shamt=4, rd=7 accepted cycle N -> out_valid cycle N+2, out_result=0xF8000000, out_rd=7, out_illegal=0.
- SLL 0x00000001 by 31 then SRL 0xFFFFFFFF by 0, out_ready held high, second in_valid waiting -> 0x80000000 then 0xFFFFFFFF, second accepted in same cycle first is consumed.
- With SHIFT_ZBB_ROT_EN: ROL 0x80000001 by 1 -> 0x00000003 at N+3; ROR 0x12345678 by 0 -> 0x12345678; without macro same ROL -> out_illegal=1, out_result=0 at N+2.
- Backpressure: SLL result held with out_ready low 5 cycles -> out_valid, out_result, out_rd stable, in_ready=0 throughout.
- Illegal funct3=000 -> out_illegal=1, out_result=0, out_valid at N+2.
- rst asserted during EXEC2 of a rotate -> next cycle all outputs 0, out_valid=0, in_ready=1 after rst drops, no stale result emitted.

Source files
------------

// File: rtl/shift_exec_ctrl.sv
// shift_exec_ctrl
//   Sequencing stage in front of the shared ALU barrel shifter. Takes a decoded
//   RV32 shift over a valid/ready handshake, registers its operands, drives the
//   combinational shifter for one cycle (two for rotates), registers the result
//   and offers it to writeback over a second valid/ready handshake.
//
// Build option:
//   SHIFT_ZBB_ROT_EN  when defined, ROL/ROR (funct7=0110000) are decoded and
//                     executed as two shifter passes whose results are OR-ed.
//                     When undefined those encodings are illegal and the
//                     second pass and its partial register do not exist.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   in_valid/in_ready               upstream handshake
//   in_funct3, in_funct7            operation decode fields
//   in_op_a, in_op_b, in_rd         rs1 value, rs2/shamt (bits [4:0]), dest tag
//   sh_opranda, sh_oprandb          shifter data and amount
//   sh_right_flag, sh_right_arith_flag  shifter direction and sign fill
//   sh_res                          shifter result (combinational)
//   out_valid/out_ready             downstream handshake
//   out_result, out_rd, out_illegal result, its tag, unsupported-op flag
//
// State   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | empty, in_ready=1
// S_EXEC1 | first (or only) shifter pass; illegal ops just record 0
// S_EXEC2 | rotate only: opposite-direction pass, OR with partial
// S_DONE  | result offered; may accept next op in the same cycle

module shift_exec_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_op_a,
  input  logic [31:0] in_op_b,
  input  logic [4:0]  in_rd,
  output logic [31:0] sh_opranda,
  output logic [4:0]  sh_oprandb,
  output logic        sh_right_flag,
  output logic        sh_right_arith_flag,
  input  logic [31:0] sh_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC1, S_EXEC2, S_DONE} state_e;
  typedef enum logic [2:0] {OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR, OP_ILL} op_e;

  state_e      state_q, state_d;
  op_e         op_q, op_d, dec_op;
  logic [31:0] op_a_q, op_a_d;
  logic [4:0]  amt_q, amt_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic        ill_q, ill_d;
  logic [31:0] sh_a_q, sh_a_d;
  logic [4:0]  sh_b_q, sh_b_d;
  logic        sh_r_q, sh_r_d;
  logic        sh_ar_q, sh_ar_d;
  logic        accept;
`ifdef SHIFT_ZBB_ROT_EN
  logic [31:0] partial_q, partial_d;
`endif

  // only the shamt field of op_b is meaningful
  logic unused_op_b;
  assign unused_op_b = ^in_op_b[31:5];

  always_comb begin
    dec_op = OP_ILL;
    if (in_funct3 == 3'b001 && in_funct7 == 7'b0000000)      dec_op = OP_SLL;
    else if (in_funct3 == 3'b101 && in_funct7 == 7'b0000000) dec_op = OP_SRL;
    else if (in_funct3 == 3'b101 && in_funct7 == 7'b0100000) dec_op = OP_SRA;
`ifdef SHIFT_ZBB_ROT_EN
    else if (in_funct3 == 3'b001 && in_funct7 == 7'b0110000) dec_op = OP_ROL;
    else if (in_funct3 == 3'b101 && in_funct7 == 7'b0110000) dec_op = OP_ROR;
`endif
  end

  // ready while empty, or while the held result is leaving this cycle
  assign in_ready = !rst && (state_q == S_IDLE || (state_q == S_DONE && out_ready));
  assign accept   = in_valid && in_ready;

  // Shifter drive kept apart from the result path: it must not depend on
  // sh_res, which is a combinational function of these very outputs.
  always_comb begin
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    sh_r_d  = sh_r_q;
    sh_ar_d = sh_ar_q;
    if (state_q == S_EXEC1 && op_q != OP_ILL) begin
      sh_a_d  = op_a_q;
      sh_b_d  = amt_q;
      sh_r_d  = (op_q == OP_SRL) || (op_q == OP_SRA) || (op_q == OP_ROR);
      sh_ar_d = (op_q == OP_SRA);
    end
`ifdef SHIFT_ZBB_ROT_EN
    else if (state_q == S_EXEC2) begin
      // (32-n) mod 32: n=0 gives a second identity pass
      sh_a_d  = op_a_q;
      sh_b_d  = 5'd0 - amt_q;
      sh_r_d  = (op_q == OP_ROL);
      sh_ar_d = 1'b0;
    end
`endif
  end

  assign sh_opranda          = sh_a_d;
  assign sh_oprandb          = sh_b_d;
  assign sh_right_flag       = sh_r_d;
  assign sh_right_arith_flag = sh_ar_d;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    op_a_d   = op_a_q;
    amt_d    = amt_q;
    rd_d     = rd_q;
    res_d    = res_q;
    out_rd_d = out_rd_q;
    ill_d    = ill_q;
`ifdef SHIFT_ZBB_ROT_EN
    partial_d = partial_q;
`endif

    if (accept) begin
      op_d   = dec_op;
      op_a_d = in_op_a;
      amt_d  = in_op_b[4:0];
      rd_d   = in_rd;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_EXEC1;
      end
      S_EXEC1: begin
        out_rd_d = rd_q;
        case (op_q)
          OP_SLL, OP_SRL, OP_SRA: begin
            res_d   = sh_res;
            ill_d   = 1'b0;
            state_d = S_DONE;
          end
`ifdef SHIFT_ZBB_ROT_EN
          OP_ROL, OP_ROR: begin
            partial_d = sh_res;
            state_d   = S_EXEC2;
          end
`endif
          default: begin
            res_d   = 32'd0;
            ill_d   = 1'b1;
            state_d = S_DONE;
          end
        endcase
      end
      S_EXEC2: begin
`ifdef SHIFT_ZBB_ROT_EN
        res_d   = partial_q | sh_res;
        ill_d   = 1'b0;
        state_d = S_DONE;
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE: begin
        if (out_ready) state_d = accept ? S_EXEC1 : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ILL;
      op_a_q   <= 32'd0;
      amt_q    <= 5'd0;
      rd_q     <= 5'd0;
      res_q    <= 32'd0;
      out_rd_q <= 5'd0;
      ill_q    <= 1'b0;
      sh_a_q   <= 32'd0;
      sh_b_q   <= 5'd0;
      sh_r_q   <= 1'b0;
      sh_ar_q  <= 1'b0;
`ifdef SHIFT_ZBB_ROT_EN
      partial_q <= 32'd0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      op_a_q   <= op_a_d;
      amt_q    <= amt_d;
      rd_q     <= rd_d;
      res_q    <= res_d;
      out_rd_q <= out_rd_d;
      ill_q    <= ill_d;
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      sh_r_q   <= sh_r_d;
      sh_ar_q  <= sh_ar_d;
`ifdef SHIFT_ZBB_ROT_EN
      partial_q <= partial_d;
`endif
    end
  end

  assign out_valid   = (state_q == S_DONE);
  assign out_result  = res_q;
  assign out_rd      = out_rd_q;
  assign out_illegal = ill_q;

endmodule

// File: tb/tb_shift_exec_ctrl.sv
module tb_shift_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_op_a;
  logic [31:0] in_op_b;
  logic [4:0]  in_rd;
  logic [31:0] sh_opranda;
  logic [4:0]  sh_oprandb;
  logic        sh_right_flag;
  logic        sh_right_arith_flag;
  logic [31:0] sh_res;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_illegal;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // external barrel shifter
  logic signed [31:0] sra_v;
  assign sra_v  = $signed(sh_opranda) >>> sh_oprandb;
  assign sh_res = sh_right_flag ? (sh_right_arith_flag ? $unsigned(sra_v) : (sh_opranda >> sh_oprandb))
                                : (sh_opranda << sh_oprandb);

  shift_exec_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_op_a(in_op_a), .in_op_b(in_op_b), .in_rd(in_rd),
    .sh_opranda(sh_opranda), .sh_oprandb(sh_oprandb),
    .sh_right_flag(sh_right_flag), .sh_right_arith_flag(sh_right_arith_flag),
    .sh_res(sh_res),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_illegal(out_illegal)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ill;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int n_total = 0;
  int n_pass  = 0;
  int force_low = 0;
  bit rand_rdy  = 0;
  bit mon_en    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
  endtask

  // Reference: RV32 shift semantics straight from the ISA definitions.
  function automatic exp_t model(input [2:0] f3, input [6:0] f7, input [31:0] a,
                                 input [31:0] b, input [4:0] rd);
    exp_t e;
    int n;
    logic signed [31:0] sa;
    n = int'(b[4:0]);
    sa = $signed(a);
    e.rd = rd; e.ill = 1'b0; e.lat = 2; e.acc = 0; e.res = 32'd0;
    if (f3 == 3'b001 && f7 == 7'h00)       e.res = a << n;
    else if (f3 == 3'b101 && f7 == 7'h00)  e.res = a >> n;
    else if (f3 == 3'b101 && f7 == 7'h20)  begin sa = sa >>> n; e.res = sa; end
`ifdef SHIFT_ZBB_ROT_EN
    else if (f3 == 3'b001 && f7 == 7'h30) begin
      e.res = (n == 0) ? a : ((a << n) | (a >> (32 - n))); e.lat = 3;
    end
    else if (f3 == 3'b101 && f7 == 7'h30) begin
      e.res = (n == 0) ? a : ((a >> n) | (a << (32 - n))); e.lat = 3;
    end
`endif
    else e.ill = 1'b1;
    return e;
  endfunction

  // monitor / scoreboard consumer
  initial begin
    logic [31:0] h_res;
    logic [4:0]  h_rd;
    logic        h_ill;
    bit held = 0;
    bit seen = 0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (force_low > 0) begin
        out_ready = 1'b0;
        if (out_valid) force_low--;
      end else begin
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      #1;
      if (!mon_en) begin held = 0; seen = 0; end
      else if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          if (!seen) begin
            check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
            seen = 1;
          end
          if (held) begin
            check("hold_result", out_result, h_res);
            check("hold_rd", {27'd0, out_rd}, {27'd0, h_rd});
            check("hold_illegal", {31'd0, out_illegal}, {31'd0, h_ill});
          end
          if (out_ready) begin
            check("result", out_result, sb[0].res);
            check("rd", {27'd0, out_rd}, {27'd0, sb[0].rd});
            check("illegal", {31'd0, out_illegal}, {31'd0, sb[0].ill});
            void'(sb.pop_front());
            seen = 0; held = 0;
          end else begin
            check("in_ready_bp", {31'd0, in_ready}, 32'd0);
            held = 1; h_res = out_result; h_rd = out_rd; h_ill = out_illegal;
          end
        end
      end else held = 0;
    end
  end

  task automatic issue(input [2:0] f3, input [6:0] f7, input [31:0] a, input [31:0] b,
                       input [4:0] rd, input bit push, output int acc);
    bit done = 0;
    exp_t e;
    acc = -1;
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = f3; in_funct7 = f7; in_op_a = a; in_op_b = b; in_rd = rd;
    for (int k = 0; k < 300 && !done; k++) begin
      #1;
      if (in_ready) begin
        done = 1; acc = cyc;
        if (push) begin
          e = model(f3, f7, a, b, rd);
          e.acc = cyc;
          sb.push_back(e);
        end
        @(posedge clk);
      end else @(negedge clk);
    end
    if (!done) check("accept_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_op_a  = $urandom;
  endtask

  task automatic drain();
    for (int k = 0; k < 600 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    int a1, a2, tmp;
    int sel;
    logic [2:0] f3;
    logic [6:0] f7;
    rst = 1'b1; in_valid = 1'b0; in_funct3 = 3'd0; in_funct7 = 7'd0;
    in_op_a = 32'd0; in_op_b = 32'd0; in_rd = 5'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_rd", {27'd0, out_rd}, 32'd0);
    check("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
    check("rst_sh_a", sh_opranda, 32'd0);
    check("rst_sh_flags", {25'd0, sh_oprandb, sh_right_flag, sh_right_arith_flag}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    mon_en = 1;

    // SRA sign fill
    issue(3'b101, 7'h20, 32'h8000_0000, 32'd4, 5'd7, 1, tmp);
    idle();
    drain();

    // back-to-back with no bubble
    issue(3'b001, 7'h00, 32'h0000_0001, 32'd31, 5'd1, 1, a1);
    issue(3'b101, 7'h00, 32'hFFFF_FFFF, 32'd0, 5'd2, 1, a2);
    idle();
    check("no_bubble_gap", 32'(a2 - a1), 32'd2);
    drain();

    // rotates (illegal in the default build), illegal funct3
    issue(3'b001, 7'h30, 32'h8000_0001, 32'd1, 5'd3, 1, tmp);
    issue(3'b101, 7'h30, 32'h1234_5678, 32'd0, 5'd4, 1, tmp);
    issue(3'b000, 7'h00, 32'hDEAD_BEEF, 32'd3, 5'd5, 1, tmp);
    idle();
    drain();

    // backpressure for 5 cycles
    force_low = 5;
    issue(3'b001, 7'h00, 32'hA5A5_0F0F, 32'd8, 5'd12, 1, tmp);
    idle();
    drain();

    // randomized traffic with random downstream stalls
    rand_rdy = 1;
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 6);
      case (sel)
        0: begin f3 = 3'b001; f7 = 7'h00; end
        1: begin f3 = 3'b101; f7 = 7'h00; end
        2: begin f3 = 3'b101; f7 = 7'h20; end
        3: begin f3 = 3'b001; f7 = 7'h30; end
        4: begin f3 = 3'b101; f7 = 7'h30; end
        5: begin f3 = 3'($urandom); f7 = 7'h20; end
        default: begin f3 = 3'($urandom); f7 = 7'($urandom); end
      endcase
      issue(f3, f7, $urandom, $urandom, 5'($urandom), 1, tmp);
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();
    drain();
    rand_rdy = 0;

    // reset in the middle of a rotate (EXEC2; EXEC1 in the default build)
    repeat (2) @(negedge clk);
    issue(3'b001, 7'h30, 32'hDEAD_BEEF, 32'd5, 5'd9, 0, tmp);
    @(negedge clk);
    in_valid = 1'b0;
`ifdef SHIFT_ZBB_ROT_EN
    @(negedge clk);
`endif
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_result", out_result, 32'd0);
    check("midrst_out_rd", {27'd0, out_rd}, 32'd0);
    check("midrst_out_illegal", {31'd0, out_illegal}, 32'd0);
    check("midrst_sh_a", sh_opranda, 32'd0);
    check("midrst_sh_flags", {25'd0, sh_oprandb, sh_right_flag, sh_right_arith_flag}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("midrst_in_ready_after", {31'd0, in_ready}, 32'd1);
    repeat (4) @(negedge clk);
    issue(3'b101, 7'h00, 32'hF000_0000, 32'd28, 5'd30, 1, tmp);
    idle();
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
